bcid_sync_checker: RTL
======================

Name: bcid_sync_checker

Overview:
- Receive-side counterpart of the readout BCID counter.
- Watches BCID values recovered from incoming frames (or from the emulated front-end) and runs a local free-running expected BCID.
- Declares lock after a run of consecutive matches and drops lock after repeated mismatches.
- Reports mismatches and keeps a saturating error count for slow-control readback.

Parameters:
- MAX_BCID, 3563, last BCID value before wrap to 0 (same constant as the generator side).
- LOCK_COUNT, 4, consecutive matching samples (including the seed sample) required to lock.
- UNLOCK_COUNT, 2, consecutive mismatching samples that drop lock.
- ERRCNT_W, 16, width of the mismatch error counter.

Ports:
- clkTMR  in  1  40 MHz bunch clock.
- resetTMR  in  1  asynchronous active-high reset.
- bcidValidTMR  in  1  bcidInTMR carries a BCID sample this cycle.
- bcidInTMR  in  12  received BCID.
- clrErrTMR  in  1  synchronous clear of errCntTMR.
- expBCIDTMR  out  12  local expected BCID for the current cycle.
- lockedTMR  out  1  high while in LOCKED.
- mismatchTMR  out  1  one-cycle pulse, a sample mismatched while LOCKED.
- lostLockTMR  out  1  one-cycle pulse on the LOCKED->IDLE transition.
- errCntTMR  out  ERRCNT_W  saturating count of LOCKED-state mismatches.

Behaviour:
- Reset (async, active-high):
  - State = IDLE, expBCIDTMR = 0, match and miss counters = 0.
  - lockedTMR, mismatchTMR, lostLockTMR = 0; errCntTMR = 0.
- expBCIDTMR free-runs every cycle in all states: value MAX_BCID -> 0, otherwise +1.
- Loading from sample B: expBCIDTMR(next) = (B == MAX_BCID) ? 0 : B + 1. A load overrides the free-run increment.
- Sample S is valid when bcidValidTMR = 1. S matches when bcidInTMR == expBCIDTMR in that same cycle.
- A sample with bcidInTMR > MAX_BCID is out-of-range: it never matches and is never loaded.
- IDLE:
  - In-range sample -> load, matchCnt = 1, go to ACQUIRE. If LOCK_COUNT == 1, go directly to LOCKED.
  - Out-of-range sample -> stay in IDLE.
- ACQUIRE:
  - Match -> matchCnt + 1; when it reaches LOCK_COUNT, go to LOCKED.
  - In-range mismatch -> reload from the sample, matchCnt = 1.
  - Out-of-range sample -> go to IDLE.
  - No sample -> hold state and count.
- LOCKED:
  - Match -> missCnt = 0.
  - Mismatch (including out-of-range) -> mismatchTMR pulse, errCntTMR + 1, missCnt + 1. expBCIDTMR is not reloaded.
  - When missCnt reaches UNLOCK_COUNT -> go to IDLE with a lostLockTMR pulse; match and miss counters are cleared.
- Output timing:
  - All outputs are registered: effects of a sample at edge t appear after edge t+1.
  - lockedTMR rises the cycle after the LOCK_COUNT-th match.
- errCntTMR:
  - Saturates at all-ones.
  - If clrErrTMR and an increment occur in the same cycle, clear wins (result 0).
  - clrErrTMR does not affect state or lock.
- Gaps: samples may be sparse (any spacing). The expected counter keeps running, so sparse samples still match when taken from the same bunch clock.
- MAX_BCID -> 0 wrap must match continuously across the boundary with no false mismatch.

Decomposition:
- Shared package/include: MAX_BCID (same `MAX_BCID_NUMBER` definition used by the generator) and the state encoding IDLE/ACQUIRE/LOCKED as localparams.
- One sub-module: bcid_wrap_counter (12-bit counter, load port, wrap at MAX_BCID). It is reusable by the emulator side.

Test Plan:
- Contiguous stream 100,101,102,103 on consecutive cycles after reset -> lockedTMR = 1 one cycle after the sample 103; errCntTMR = 0.
- Locked stream crossing 3562,3563,0,1 -> no mismatchTMR; expBCIDTMR shows 3563 -> 0.
- Locked, single wrong sample (500 when 700 expected) -> one mismatchTMR pulse, errCntTMR = 1, lockedTMR stays 1; the next correct sample resets missCnt.
- Locked, two consecutive wrong samples -> lostLockTMR pulse, lockedTMR = 0, state IDLE; a fresh stream relocks after 4 matches.
- ACQUIRE with 10,11 then 50 (jump) -> reload, matchCnt = 1; lock needs 51,52,53. Sample 4000 in IDLE -> stays IDLE.
- errCntTMR forced to 0xFFFF plus a mismatch -> stays 0xFFFF; clrErrTMR coinciding with a mismatch -> 0.

Source files
------------

// File: rtl/bcid_sync_checker_pkg.sv
// Shared constants and state encoding for the BCID generator and receive-side sync checker.
package bcid_sync_checker_pkg;

  localparam int BCID_W = 12;
  localparam int CNT_W  = 8;

  // Same last-BCID value as the generator side; the counter wraps to 0 after it.
  localparam logic [BCID_W-1:0] MAX_BCID_NUMBER = 12'd3563;
  localparam logic [BCID_W-1:0] MAX_BCID        = MAX_BCID_NUMBER;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  typedef logic [BCID_W-1:0] bcid_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ACQUIRE = ST_ACQUIRE,
    LOCKED  = ST_LOCKED
  } state_t;

  function automatic bcid_t nextBcid(input bcid_t b);
    return (b == MAX_BCID) ? '0 : b + 12'd1;
  endfunction

endpackage

// File: rtl/bcid_sync_checker_if.sv
// Sample input and status output bundle of the BCID sync checker.
interface bcid_sync_checker_if #(
  parameter int ERRCNT_W = 16
);
  import bcid_sync_checker_pkg::*;

  logic                bcidValidTMR;
  bcid_t               bcidInTMR;
  logic                clrErrTMR;
  bcid_t               expBCIDTMR;
  logic                lockedTMR;
  logic                mismatchTMR;
  logic                lostLockTMR;
  logic [ERRCNT_W-1:0] errCntTMR;

  modport master (
    output bcidValidTMR, bcidInTMR, clrErrTMR,
    input  expBCIDTMR, lockedTMR, mismatchTMR, lostLockTMR, errCntTMR
  );

  modport slave (
    input  bcidValidTMR, bcidInTMR, clrErrTMR,
    output expBCIDTMR, lockedTMR, mismatchTMR, lostLockTMR, errCntTMR
  );

endinterface

// File: rtl/bcid_sync_checker_wrap_counter.sv
// Free-running BCID counter wrapping at MAX_BCID; a load seeds it with the value after loadValue.
module bcid_wrap_counter
  import bcid_sync_checker_pkg::*;
(
  input  logic  clkTMR,
  input  logic  resetTMR,
  input  logic  load,
  input  bcid_t loadValue,
  output bcid_t count
);

  always_ff @(posedge clkTMR or posedge resetTMR) begin
    if (resetTMR) begin
      count <= '0;
    end else begin
      count <= nextBcid(load ? loadValue : count);
    end
  end

endmodule

// File: rtl/bcid_sync_checker.sv
// Receive-side BCID checker: tracks a local expected BCID, locks onto the incoming stream, counts mismatches.
module bcid_sync_checker
  import bcid_sync_checker_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int ERRCNT_W     = 16
)(
  input  logic                clkTMR,
  input  logic                resetTMR,
  bcid_sync_checker_if.slave  bus
);

  localparam cnt_t LOCK_TARGET   = cnt_t'(LOCK_COUNT);
  localparam cnt_t UNLOCK_TARGET = cnt_t'(UNLOCK_COUNT);

  state_t              state;
  state_t              stateNext;
  cnt_t                matchCnt;
  cnt_t                matchCntNext;
  cnt_t                missCnt;
  cnt_t                missCntNext;
  bcid_t               expBcid;
  logic                inRange;
  logic                isMatch;
  logic                load;
  logic                mismatchNext;
  logic                lostLockNext;
  logic                mismatchReg;
  logic                lostLockReg;
  logic [ERRCNT_W-1:0] errCnt;

  bcid_wrap_counter expCounter (
    .clkTMR    (clkTMR),
    .resetTMR  (resetTMR),
    .load      (load),
    .loadValue (bus.bcidInTMR),
    .count     (expBcid)
  );

  assign inRange = (bus.bcidInTMR <= MAX_BCID);
  assign isMatch = bus.bcidValidTMR && inRange && (bus.bcidInTMR == expBcid);

  always_ff @(posedge clkTMR or posedge resetTMR) begin
    if (resetTMR) begin
      state       <= IDLE;
      matchCnt    <= '0;
      missCnt     <= '0;
      mismatchReg <= 1'b0;
      lostLockReg <= 1'b0;
      errCnt      <= '0;
    end else begin
      state       <= stateNext;
      matchCnt    <= matchCntNext;
      missCnt     <= missCntNext;
      mismatchReg <= mismatchNext;
      lostLockReg <= lostLockNext;
      if (bus.clrErrTMR) begin
        errCnt <= '0;
      end else if (mismatchNext && (errCnt != '1)) begin
        errCnt <= errCnt + 1'b1;
      end
    end
  end

  always_comb begin
    stateNext    = state;
    matchCntNext = matchCnt;
    missCntNext  = missCnt;
    if (bus.bcidValidTMR) begin
      case (state)
        IDLE: begin
          if (inRange) begin
            matchCntNext = cnt_t'(1);
            stateNext    = (LOCK_TARGET <= cnt_t'(1)) ? LOCKED : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (isMatch) begin
            matchCntNext = matchCnt + cnt_t'(1);
            if (matchCnt + cnt_t'(1) >= LOCK_TARGET) stateNext = LOCKED;
          end else if (inRange) begin
            matchCntNext = cnt_t'(1);
          end else begin
            stateNext    = IDLE;
            matchCntNext = '0;
          end
        end
        LOCKED: begin
          // The expected counter is never reloaded here; only the miss run is tracked.
          if (isMatch) begin
            missCntNext = '0;
          end else if (missCnt + cnt_t'(1) >= UNLOCK_TARGET) begin
            stateNext    = IDLE;
            matchCntNext = '0;
            missCntNext  = '0;
          end else begin
            missCntNext = missCnt + cnt_t'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    load         = bus.bcidValidTMR && inRange &&
                   ((state == IDLE) || ((state == ACQUIRE) && !isMatch));
    mismatchNext = bus.bcidValidTMR && (state == LOCKED) && !isMatch;
    lostLockNext = mismatchNext && (missCnt + cnt_t'(1) >= UNLOCK_TARGET);
  end

  assign bus.expBCIDTMR  = expBcid;
  assign bus.lockedTMR   = (state == LOCKED);
  assign bus.mismatchTMR = mismatchReg;
  assign bus.lostLockTMR = lostLockReg;
  assign bus.errCntTMR   = errCnt;

endmodule
